// File: rtl/bk_pkg.sv
// Shared types and constants for the BSRAM save/load sequencer.
package bk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACTIVE
    } bk_state_t;

    typedef enum logic {
        LOAD,
        SAVE
    } bk_op_t;

    localparam int SECTOR_SHIFT = 9;

    // Index of the last 512-byte sector covered by the cartridge RAM mask.
    function automatic logic [31:0] last_lba_of(input logic [23:0] mask);
        return 32'(mask >> SECTOR_SHIFT);
    endfunction

endpackage

// File: rtl/bk_edge.sv
// One-bit registered rise/fall detector; edges are reported while the old sample differs.
module bk_edge (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic old;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) old <= 1'b0;
        else          old <= level;
    end

    assign rise = level & ~old;
    assign fall = ~level & old;

endmodule

// File: rtl/bsram_save_ctrl.sv
// Sequences per-sector BSRAM load/save transfers over the HPS SD interface and tracks dirty state.
module bsram_save_ctrl
    import bk_pkg::*;
#(
    parameter logic [23:0] ACK_TIMEOUT = 24'd10_000_000
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        enable,
    input  logic [23:0] ram_mask,
    input  logic        load_req,
    input  logic        save_req,
    input  logic        dl_active,
    input  logic        bsram_wr,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        loading,
    output logic        busy,
    output logic        dirty,
    output logic        error
);

    logic load_rise, load_fall, save_rise, save_fall;
    logic dl_rise, dl_fall, ack_rise, ack_fall;

    bk_edge u_load_edge (.clk_sys(clk_sys), .reset_n(RESET_N), .level(load_req),  .rise(load_rise), .fall(load_fall));
    bk_edge u_save_edge (.clk_sys(clk_sys), .reset_n(RESET_N), .level(save_req),  .rise(save_rise), .fall(save_fall));
    bk_edge u_dl_edge   (.clk_sys(clk_sys), .reset_n(RESET_N), .level(dl_active), .rise(dl_rise),   .fall(dl_fall));
    bk_edge u_ack_edge  (.clk_sys(clk_sys), .reset_n(RESET_N), .level(sd_ack),    .rise(ack_rise),  .fall(ack_fall));

    // Request falls carry no meaning here.
    logic unused_falls;
    assign unused_falls = load_fall ^ save_fall;

    // Edge detectors reset to 0, so a level still high after reset would look like a
    // fresh edge; requests are ignored for the first cycle while the detectors settle.
    logic armed;

    bk_state_t   state, state_nx;
    bk_op_t      op, op_nx;
    logic [31:0] lba, lba_nx, last_lba;
    logic [23:0] timer, timer_nx;
    logic        accept, done, timed_out;
    logic        req_auto, req_load, req_save, req_any, can_accept;
    logic        busy_nx, rd_nx, wr_nx, loading_nx, dirty_nx, error_nx;

    assign last_lba   = last_lba_of(ram_mask);
    assign can_accept = enable && (ram_mask != 24'd0);
    assign req_auto   = armed && dl_fall && enable;
    assign req_load   = armed && load_rise;
    assign req_save   = armed && save_rise;
    assign req_any    = req_auto || req_load || req_save;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            armed   <= 1'b0;
            state   <= IDLE;
            op      <= LOAD;
            lba     <= '0;
            timer   <= '0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            loading <= 1'b0;
            busy    <= 1'b0;
            dirty   <= 1'b0;
            error   <= 1'b0;
        end else begin
            armed   <= 1'b1;
            state   <= state_nx;
            op      <= op_nx;
            lba     <= lba_nx;
            timer   <= timer_nx;
            sd_rd   <= rd_nx;
            sd_wr   <= wr_nx;
            loading <= loading_nx;
            busy    <= busy_nx;
            dirty   <= dirty_nx;
            error   <= error_nx;
        end
    end

    assign sd_lba = lba;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_nx  = state;
        op_nx     = op;
        lba_nx    = lba;
        timer_nx  = timer + 24'd1;
        accept    = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        unique case (state)
            IDLE: begin
                timer_nx = timer;
                if (can_accept && req_any) begin
                    accept   = 1'b1;
                    state_nx = ISSUE;
                    op_nx    = (req_auto || req_load) ? LOAD : SAVE;
                    lba_nx   = '0;
                    timer_nx = '0;
                end
            end
            ISSUE, ACTIVE: begin
                if (dl_rise) begin
                    state_nx = IDLE;
                end else if (timer_nx == ACK_TIMEOUT) begin
                    timed_out = 1'b1;
                    state_nx  = IDLE;
                end else if (state == ISSUE && ack_rise) begin
                    state_nx = ACTIVE;
                end else if (state == ACTIVE && ack_fall) begin
                    if (lba >= last_lba) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        lba_nx   = lba + 32'd1;
                        timer_nx = '0;
                        state_nx = ISSUE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state; dirty updates are ordered so
    // later lines win (a dl_active rise always leaves BSRAM clean).
    always_comb begin
        busy_nx    = (state_nx != IDLE);
        rd_nx      = (state_nx == ISSUE) && (op_nx == LOAD);
        wr_nx      = (state_nx == ISSUE) && (op_nx == SAVE);
        loading_nx = busy_nx && (op_nx == LOAD);

        error_nx = error;
        if (accept)    error_nx = 1'b0;
        if (timed_out) error_nx = 1'b1;

        dirty_nx = dirty;
        if (accept && op_nx == SAVE)  dirty_nx = 1'b0;
        if (done && op == LOAD)       dirty_nx = 1'b0;
        if (timed_out && op == SAVE)  dirty_nx = 1'b1;
        if (bsram_wr && !loading)     dirty_nx = 1'b1;
        if (dl_rise)                  dirty_nx = 1'b0;
    end

endmodule
